// File: rtl/arm_pkg.sv
// arm_pkg: shared ARM datapath types, register constants and the writeback stage record
package arm_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  regaddr_t;

    localparam regaddr_t REG_LR = 4'd14;
    localparam regaddr_t REG_PC = 4'd15;

    typedef struct packed {
        logic     valid;
        logic     regwrite;
        logic     memtoreg;
        logic     link;
        logic     cond_ok;
        regaddr_t wa;
        word_t    aluresult;
        word_t    readdata;
        word_t    pc4;
    } wb_stage_t;

endpackage

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: pipeline-control, upstream instruction and register-file write bundle
interface writeback_stage_if;
    import arm_pkg::*;

    logic     stall;
    logic     flush;
    logic     in_valid;
    logic     in_regwrite;
    logic     in_memtoreg;
    logic     in_link;
    logic     in_cond_ok;
    regaddr_t in_wa;
    word_t    in_aluresult;
    word_t    in_readdata;
    word_t    in_pc4;
    logic     we3;
    regaddr_t wa3;
    word_t    wd3;
    logic     link;
    word_t    pc4;
    logic     pc_write;
    word_t    pc_wdata;

    modport master (
        output stall, flush, in_valid, in_regwrite, in_memtoreg, in_link, in_cond_ok,
               in_wa, in_aluresult, in_readdata, in_pc4,
        input  we3, wa3, wd3, link, pc4, pc_write, pc_wdata
    );

    modport slave (
        input  stall, flush, in_valid, in_regwrite, in_memtoreg, in_link, in_cond_ok,
               in_wa, in_aluresult, in_readdata, in_pc4,
        output we3, wa3, wd3, link, pc4, pc_write, pc_wdata
    );

endinterface

// File: rtl/wb_perf_counter.sv
// wb_perf_counter: 32-bit wrapping count of committed instructions
module wb_perf_counter
    import arm_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  inc,
    output word_t count
);

    word_t cnt_q;

    // count one per commit, wrapping naturally at 32 bits
    always_ff @(posedge clk)
        if (reset) cnt_q <= '0;
        else if (inc) cnt_q <= cnt_q + 32'd1;

    assign count = cnt_q;

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline register driving register-file writes, link and PC redirect.
// Defining WB_PERF_CNT_EN adds a retired-instruction counter and the retired port.
module writeback_stage
    import arm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    writeback_stage_if.slave bus
`ifdef WB_PERF_CNT_EN
    ,
    output word_t retired
`endif
);

    wb_stage_t st;
    logic      commit;
    logic      link_c;
    word_t     result;

    // capture the incoming instruction; flush squashes it even when stalled
    always_ff @(posedge clk)
        if (reset) st <= '0;
        else if (bus.flush) st.valid <= 1'b0;
        else if (!bus.stall) st <= '{
            valid:     bus.in_valid,
            regwrite:  bus.in_regwrite,
            memtoreg:  bus.in_memtoreg,
            link:      bus.in_link,
            cond_ok:   bus.in_cond_ok,
            wa:        bus.in_wa,
            aluresult: bus.in_aluresult,
            readdata:  bus.in_readdata,
            pc4:       bus.in_pc4
        };

    // a stalled instruction commits later, in its first unstalled cycle
    assign commit = st.valid & st.cond_ok & ~bus.stall;
    assign link_c = commit & st.link;
    assign result = st.memtoreg ? st.readdata : st.aluresult;

    // the link write owns R14, and R15 goes through the redirect path instead
    assign bus.we3      = commit & st.regwrite & (st.wa != REG_PC) & ~(link_c & (st.wa == REG_LR));
    assign bus.wa3      = st.wa;
    assign bus.wd3      = result;
    assign bus.link     = link_c;
    assign bus.pc4      = st.pc4;
    assign bus.pc_write = commit & st.regwrite & (st.wa == REG_PC);
    assign bus.pc_wdata = result;

`ifdef WB_PERF_CNT_EN
    wb_perf_counter u_perf (
        .clk   (clk),
        .reset (reset),
        .inc   (commit),
        .count (retired)
    );
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scenarios with a scoreboard of expected writeback events
module tb_writeback_stage;
    import arm_pkg::*;

    typedef struct {
        int          kind;
        logic [3:0]  addr;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    ev_t  sb[$];

    writeback_stage_if bus();

`ifdef WB_PERF_CNT_EN
    word_t retired;
    word_t r0;
`endif

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WB_PERF_CNT_EN
        ,
        .retired (retired)
`endif
    );

    ev_t         exp_ev;
    logic        hit;
    logic [3:0]  got_a;
    logic [31:0] got_d;

    // scoreboard monitor: channels in order reg write (0), link (1), pc redirect (2)
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                hit   = (k == 0) ? bus.we3 : (k == 1) ? bus.link : bus.pc_write;
                got_a = (k == 0) ? bus.wa3 : (k == 1) ? 4'd14 : 4'd15;
                got_d = (k == 0) ? bus.wd3 : (k == 1) ? bus.pc4 : bus.pc_wdata;
                if (hit) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected kind=%0d addr=%0d data=%h required no event", k, got_a, got_d);
                    end else begin
                        exp_ev = sb.pop_front();
                        if (exp_ev.kind !== k || exp_ev.addr !== got_a || exp_ev.data !== got_d) begin
                            errors++;
                            $display("FAIL sb_event got kind=%0d addr=%0d data=%h required kind=%0d addr=%0d data=%h",
                                     k, got_a, got_d, exp_ev.kind, exp_ev.addr, exp_ev.data);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.in_regwrite  = 1'b0;
        bus.in_memtoreg  = 1'b0;
        bus.in_link      = 1'b0;
        bus.in_cond_ok   = 1'b0;
        bus.in_wa        = '0;
        bus.in_aluresult = '0;
        bus.in_readdata  = '0;
        bus.in_pc4       = '0;
    endtask

    task automatic send(input logic rw, input logic mtr, input logic lk, input logic ok,
                        input logic [3:0] wa, input logic [31:0] alu, input logic [31:0] rd,
                        input logic [31:0] p4, input logic exp);
        logic [31:0] res;
        bus.in_valid     = 1'b1;
        bus.in_regwrite  = rw;
        bus.in_memtoreg  = mtr;
        bus.in_link      = lk;
        bus.in_cond_ok   = ok;
        bus.in_wa        = wa;
        bus.in_aluresult = alu;
        bus.in_readdata  = rd;
        bus.in_pc4       = p4;
        res = mtr ? rd : alu;
        if (exp && ok) begin
            if (rw && wa != 4'd15 && !(lk && wa == 4'd14)) sb.push_back('{0, wa, res});
            if (lk) sb.push_back('{1, 4'd14, p4});
            if (rw && wa == 4'd15) sb.push_back('{2, 4'd15, res});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        idle();
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.we3, bus.link, bus.pc_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got %b required 000", {bus.we3, bus.link, bus.pc_write});
        end
`ifdef WB_PERF_CNT_EN
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_retired got %h required 0", retired);
        end
`endif
    endtask

    task automatic test_alu_write();
        tick();
        send(1, 0, 0, 1, 4'd3, 32'h1F, 32'h0, 32'h0, 1);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd3 || bus.wd3 !== 32'h1F) begin
            errors++;
            $display("FAIL alu_write got we3=%b wa3=%0d wd3=%h required we3=1 wa3=3 wd3=1f", bus.we3, bus.wa3, bus.wd3);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.we3 !== 1'b0) begin
            errors++;
            $display("FAIL alu_write_once got we3=%b required 0", bus.we3);
        end
    endtask

    task automatic test_load_stall();
`ifdef WB_PERF_CNT_EN
        r0 = retired;
`endif
        tick();
        send(1, 1, 0, 1, 4'd5, 32'hDEAD, 32'hCAFE, 32'h0, 1);
        tick();
        idle();
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.we3 !== 1'b0) begin
                errors++;
                $display("FAIL load_stall_%0d got we3=%b required 0", i, bus.we3);
            end
            if (i == 0) tick();
        end
        tick();
        bus.stall = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.we3 !== 1'b1 || bus.wa3 !== 4'd5 || bus.wd3 !== 32'hCAFE) begin
            errors++;
            $display("FAIL load_release got we3=%b wa3=%0d wd3=%h required we3=1 wa3=5 wd3=cafe", bus.we3, bus.wa3, bus.wd3);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.we3 !== 1'b0) begin
            errors++;
            $display("FAIL load_once got we3=%b required 0", bus.we3);
        end
`ifdef WB_PERF_CNT_EN
        checks++;
        if (retired !== r0 + 32'd1) begin
            errors++;
            $display("FAIL load_retired got %h required %h", retired, r0 + 32'd1);
        end
`endif
    endtask

    task automatic test_r15_write();
        tick();
        send(1, 0, 0, 1, 4'd15, 32'h100, 32'h0, 32'h0, 1);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (bus.pc_write !== 1'b1 || bus.pc_wdata !== 32'h100 || bus.we3 !== 1'b0) begin
            errors++;
            $display("FAIL r15_write got pc_write=%b pc_wdata=%h we3=%b required 1 100 0", bus.pc_write, bus.pc_wdata, bus.we3);
        end
    endtask

    task automatic test_link_conflict();
        tick();
        send(1, 0, 1, 1, 4'd14, 32'h55, 32'h0, 32'h44, 1);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (bus.link !== 1'b1 || bus.pc4 !== 32'h44 || bus.we3 !== 1'b0) begin
            errors++;
            $display("FAIL link_conflict got link=%b pc4=%h we3=%b required 1 44 0", bus.link, bus.pc4, bus.we3);
        end
    endtask

    task automatic test_back_to_back();
        tick();
        send(1, 0, 0, 1, 4'd1, 32'h11, 32'h0, 32'h0, 1);
        tick();
        send(1, 1, 0, 1, 4'd2, 32'h0, 32'h2222, 32'h0, 1);
        tick();
        send(1, 0, 1, 1, 4'd9, 32'h99, 32'h0, 32'h1004, 1);
        tick();
        send(1, 1, 0, 1, 4'd15, 32'h0, 32'h8000, 32'h0, 1);
        tick();
        idle();
        tick();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back_pending got %0d events left required 0", sb.size());
        end
    endtask

    task automatic test_flush_stall();
`ifdef WB_PERF_CNT_EN
        r0 = retired;
`endif
        tick();
        send(1, 0, 0, 1, 4'd7, 32'h77, 32'h0, 32'h0, 0);
        tick();
        idle();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.we3 !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall_hold got we3=%b required 0", bus.we3);
        end
        tick();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.we3, bus.link, bus.pc_write} !== 3'b000) begin
            errors++;
            $display("FAIL flush_stall_after got %b required 000", {bus.we3, bus.link, bus.pc_write});
        end
        send(1, 0, 1, 1, 4'd8, 32'h88, 32'h0, 32'h8, 0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if ({bus.we3, bus.link, bus.pc_write} !== 3'b000) begin
            errors++;
            $display("FAIL flush_incoming got %b required 000", {bus.we3, bus.link, bus.pc_write});
        end
        tick();
        send(1, 0, 1, 0, 4'd4, 32'h44, 32'h0, 32'h4, 1);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({bus.we3, bus.link, bus.pc_write} !== 3'b000) begin
            errors++;
            $display("FAIL cond_fail got %b required 000", {bus.we3, bus.link, bus.pc_write});
        end
`ifdef WB_PERF_CNT_EN
        checks++;
        if (retired !== r0) begin
            errors++;
            $display("FAIL cond_fail_retired got %h required %h", retired, r0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        tick();
        send(1, 0, 0, 1, 4'd6, 32'h66, 32'h0, 32'h0, 0);
        tick();
        idle();
        reset = 1'b1;
        bus.stall = 1'b1;
        tick();
        reset = 1'b0;
        bus.stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.we3, bus.link, bus.pc_write} !== 3'b000 || bus.wd3 !== 32'h0 || bus.wa3 !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid got strobes=%b wa3=%0d wd3=%h required 000 0 0",
                     {bus.we3, bus.link, bus.pc_write}, bus.wa3, bus.wd3);
        end
`ifdef WB_PERF_CNT_EN
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_retired got %h required 0", retired);
        end
`endif
    endtask

`ifdef WB_PERF_CNT_EN
    task automatic test_wrap();
        @(negedge clk);
        force dut.u_perf.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_perf.cnt_q;
        checks++;
        if (retired !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preset got %h required ffffffff", retired);
        end
        tick();
        send(1, 0, 0, 1, 4'd1, 32'hA5, 32'h0, 32'h0, 1);
        tick();
        idle();
        tick();
        @(negedge clk);
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL wrap got %h required 0", retired);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_write();
        test_load_stall();
        test_r15_write();
        test_link_conflict();
        test_back_to_back();
        test_flush_stall();
        test_reset_mid();
`ifdef WB_PERF_CNT_EN
        test_wrap();
`endif
        tick();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d events left required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
